// File: rtl/uart_tx_streamer_pkg.sv
// Shared constants and types for the uart byte streamer: uart register map,
// streamer FSM encodings and the register-port request bundle.
package uart_tx_streamer_pkg;

    localparam logic [2:0] UART_MUX_CTRL = 3'd0;
    localparam logic [2:0] UART_MUX_STAT = 3'd1;
    localparam logic [2:0] UART_MUX_TDR  = 3'd2;
    localparam logic [2:0] UART_MUX_RDR  = 3'd3;
    localparam logic [2:0] UART_MUX_BAUD = 3'd4;

    typedef enum logic [2:0] {
        UTS_INIT       = 3'd0,
        UTS_IDLE       = 3'd1,
        UTS_LOAD_TDR   = 3'd2,
        UTS_SET_GO     = 3'd3,
        UTS_WAIT_START = 3'd4,
        UTS_WAIT_DONE  = 3'd5
    } uts_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  reg_num;
        logic [31:0] wd;
    } uart_req_t;

    // Parked port: a harmless STAT read, never RDR (reading RDR has side effects).
    localparam uart_req_t UART_REQ_IDLE = '{we: 1'b0, reg_num: UART_MUX_STAT, wd: 32'd0};

    function automatic uart_req_t uart_write(input logic [2:0] r, input logic [31:0] d);
        uart_req_t q;
        q.we      = 1'b1;
        q.reg_num = r;
        q.wd      = d;
        return q;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrapping pointers and a separate occupancy count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_streamer.sv
// Byte-stream front end that owns a uart register port: queues bytes, then per
// byte writes TDR, sets CTRL[0] and polls STAT[1] through start and completion.
module uart_tx_streamer
    import uart_tx_streamer_pkg::*;
#(
    parameter int          DEPTH         = 8,
    parameter logic [31:0] BAUD_DIV      = 32'd16,
    parameter int          START_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     err,
    output logic                     uart_we,
    output logic [2:0]               uart_reg_num,
    output logic [31:0]              uart_wd,
    input  logic [31:0]              uart_rd
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    uts_state_e  state;
    uts_state_e  nxt;
    uart_req_t   req_d;
    uart_req_t   req_q;
    logic [TW-1:0] tmo;
    logic        set_err;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        fifo_pop;
    logic        stat_busy;
    logic        unused_rd;

    assign stat_busy = uart_rd[1];
    assign unused_rd = ^{uart_rd[31:2], uart_rd[0]};

    assign in_ready  = ~fifo_full;
    assign fifo_pop  = (state == UTS_LOAD_TDR);
    assign busy      = (state != UTS_IDLE) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid & in_ready),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

    always_comb begin
        nxt     = state;
        set_err = 1'b0;
        case (state)
            UTS_INIT:     nxt = UTS_IDLE;
            UTS_IDLE:     if (level != '0) nxt = UTS_LOAD_TDR;
            UTS_LOAD_TDR: nxt = UTS_SET_GO;
            UTS_SET_GO:   nxt = UTS_WAIT_START;
            UTS_WAIT_START: begin
                // tmo==0 marks the first cycle, whose uart_rd still reflects the CTRL write.
                if (tmo != '0 && stat_busy) begin
                    nxt = UTS_WAIT_DONE;
                end else if (tmo == TW'(START_TIMEOUT - 1)) begin
                    nxt     = UTS_IDLE;
                    set_err = 1'b1;
                end
            end
            UTS_WAIT_DONE: if (!stat_busy) nxt = UTS_IDLE;
            default:       nxt = UTS_INIT;
        endcase
    end

    // Port drive is registered from the state being entered, so the bus always
    // shows the access belonging to the current state; INIT's exit carries BAUD.
    always_comb begin
        req_d = UART_REQ_IDLE;
        if (state == UTS_INIT) begin
            req_d = uart_write(UART_MUX_BAUD, BAUD_DIV);
        end else begin
            case (nxt)
                UTS_LOAD_TDR: req_d = uart_write(UART_MUX_TDR, {24'b0, fifo_head});
                UTS_SET_GO:   req_d = uart_write(UART_MUX_CTRL, 32'h1);
                default:      req_d = UART_REQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UTS_INIT;
            req_q <= UART_REQ_IDLE;
            tmo   <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            req_q <= req_d;
            if (set_err) err <= 1'b1;
            if (state != UTS_WAIT_START)
                tmo <= '0;
            else if (tmo != TW'(START_TIMEOUT))
                tmo <= tmo + 1'b1;
        end
    end

    assign uart_we      = req_q.we;
    assign uart_reg_num = req_q.reg_num;
    assign uart_wd      = req_q.wd;

endmodule
